// File: rtl/div_arbiter.sv
// div_arbiter
//   Two-port arbiter and sequencer in front of one shared multi-cycle divider.
//   A winning request has its operands captured at the grant edge. The block
//   then pulses div_start once, waits for div_done and returns the quotient and
//   remainder to the owning port with a one-cycle response strobe.
//
// Parameters
//   W             operand/result width
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset (shared with the divider)
//   req0/req1     level requests; a*/b* valid while high
//   a0/a1, b0/b1  dividend / divisor per port
//   gnt0/gnt1     grant, combinational, IDLE only; operands captured this edge
//   rsp_valid0/1  one-cycle response strobe for the owning port
//   rsp_q/rsp_r   quotient / remainder, held until the next response
//   rsp_err       divide-by-zero flag, valid with the strobe
//   busy          high whenever a transaction is in progress
//   div_start     one-cycle start pulse to the divider
//   div_dividend/div_divisor  registered operands presented to the divider
//   div_done      divider completion pulse, honoured only while waiting
//   div_q/div_r   divider results, sampled with div_done
//
// Build option
//   DIV_ARB_ZERO_CHK_EN  when defined, a granted zero divisor is answered
//                        directly (q = all ones, r = dividend, rsp_err = 1)
//                        without starting the divider. When undefined a zero
//                        divisor goes to the divider and rsp_err is tied to 0.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and grant
// LAUNCH | pulse div_start
// WAIT   | wait for div_done, capture results
// RESP   | strobe rsp_valid of the owner

module div_arbiter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_err,
  output logic         busy,
  output logic         div_start,
  output logic [W-1:0] div_dividend,
  output logic [W-1:0] div_divisor,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         ptr;
  logic         owner;
  logic         win_vld;
  logic         win_id;
  logic [W-1:0] win_a;
  logic [W-1:0] win_b;
  logic         zero_skip;
  logic         capture;
  logic         load_rsp;

  // A lone requester wins outright; on a tie the pointer decides.
  assign win_vld = req0 | req1;
  assign win_id  = (req0 & req1) ? ptr : req1;
  assign win_a   = win_id ? a1 : a0;
  assign win_b   = win_id ? b1 : b0;

`ifdef DIV_ARB_ZERO_CHK_EN
  assign zero_skip = (win_b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    div_start  = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    busy       = 1'b1;
    capture    = 1'b0;
    load_rsp   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (win_vld) begin
          gnt0      = ~win_id;
          gnt1      = win_id;
          capture   = 1'b1;
          state_nxt = zero_skip ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          load_rsp  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid0 = ~owner;
        rsp_valid1 = owner;
        state_nxt  = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rsp_q        <= '0;
      rsp_r        <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        owner        <= win_id;
        ptr          <= ~win_id;
        div_dividend <= win_a;
        div_divisor  <= win_b;
      end
      if (load_rsp) begin
        rsp_q <= div_q;
        rsp_r <= div_r;
      end else if (capture && zero_skip) begin
        rsp_q <= '1;
        rsp_r <= win_a;
      end
    end
  end

`ifdef DIV_ARB_ZERO_CHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (load_rsp) begin
      err_q <= 1'b0;
    end else if (capture && zero_skip) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, busy, div_start;
  logic [W-1:0] rsp_q, rsp_r, div_dividend, div_divisor;
  logic         div_done;
  logic [W-1:0] div_q, div_r;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // divider model state (stimulus)
  int           dly = 8;
  int           dv_cnt = 0;
  logic [W-1:0] dv_a, dv_b;

  // passive observation
  int           n_start = 0;
  int           last_start_cyc = -100;
  logic [W-1:0] st_a, st_b;
  int           n_rsp = 0;
  int           n_dual = 0;

  div_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_start) begin
      n_start++;
      last_start_cyc = cyc;
      st_a = div_dividend;
      st_b = div_divisor;
    end
    if (rsp_valid0 || rsp_valid1) n_rsp++;
    if ((gnt0 && gnt1) || (rsp_valid0 && rsp_valid1)) n_dual++;
  end

  function automatic logic [4*W+6:0] outs();
    return {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_q, rsp_r, rsp_err, busy,
            div_start, div_dividend, div_divisor};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    return W'($urandom_range(0, 63));
  endfunction

  function automatic logic [W-1:0] rnd_b();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 63));
  endfunction

  // One clock; returns 1 ns after the rising edge with the divider model advanced.
  // A start seen in cycle S produces div_done in cycle S+dly.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    div_done = 1'b0;
    if (last_start_cyc == cyc - 1) begin
      dv_cnt = dly;
      dv_a   = st_a;
      dv_b   = st_b;
    end
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        div_done = 1'b1;
        div_q    = (dv_b == '0) ? {W{1'b1}} : dv_a / dv_b;
        div_r    = (dv_b == '0) ? dv_a : dv_a % dv_b;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; div_done = 1'b0; dv_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int port, output int at);
    port = -1;
    at   = -1;
    for (int k = 0; k < max; k++) begin
      tick();
      #1;
      if (rsp_valid0 || rsp_valid1) begin
        port = rsp_valid1 ? 1 : 0;
        at   = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    div_done = 1'b0; div_q = '0; div_r = '0;
    #1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_outs got=%0h exp=0", outs()); end
    tick(); tick();
    rst = 1'b0;
    tick();
    #1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_idle got=%0h exp=0", outs()); end
  endtask

  task automatic test_basic();
    int t0, port, at;
    do_reset();
    dly = 8;
    tick();
    req0 = 1'b1; a0 = 6'd45; b0 = 6'd6;
    #1;
    t0 = cyc;
    total++;
    if ({gnt1, gnt0} !== 2'b01) begin bad++; $display("FAIL basic_gnt got=%b exp=01", {gnt1, gnt0}); end
    tick();
    req0 = 1'b0;
    #1;
    total++;
    if (div_start !== 1'b1 || div_dividend !== 6'd45 || div_divisor !== 6'd6) begin
      bad++; $display("FAIL basic_start got=%b/%0d/%0d exp=1/45/6", div_start, div_dividend, div_divisor);
    end
    wait_rsp(20, port, at);
    total++;
    if (port !== 0 || at !== t0 + 10) begin bad++; $display("FAIL basic_rsp_time got=p%0d@%0d exp=p0@%0d", port, at, t0 + 10); end
    total++;
    if (rsp_q !== 6'd7 || rsp_r !== 6'd3 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL basic_rsp_val got=%0d/%0d/%b exp=7/3/0", rsp_q, rsp_r, rsp_err);
    end
    tick();
    #1;
    total++;
    if (rsp_valid0 !== 1'b0 || busy !== 1'b0 || rsp_q !== 6'd7) begin
      bad++; $display("FAIL basic_after got=%b/%b/%0d exp=0/0/7", rsp_valid0, busy, rsp_q);
    end
  endtask

  task automatic test_tie();
    int port, at;
    do_reset();
    dly = 3;
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      req0 = 1'b1; req1 = 1'b1; a0 = 6'd20; b0 = 6'd3; a1 = 6'd30; b1 = 6'd4;
      #1;
      total++;
      if ({gnt1, gnt0} !== 2'b01) begin bad++; $display("FAIL tie_first rep%0d got=%b exp=01", rep, {gnt1, gnt0}); end
      tick();
      req0 = 1'b0;
      wait_rsp(20, port, at);
      total++;
      if (port !== 0 || rsp_q !== 6'd6 || rsp_r !== 6'd2) begin
        bad++; $display("FAIL tie_rsp0 rep%0d got=p%0d %0d/%0d exp=p0 6/2", rep, port, rsp_q, rsp_r);
      end
      tick();
      #1;
      total++;
      if ({gnt1, gnt0} !== 2'b10) begin bad++; $display("FAIL tie_second rep%0d got=%b exp=10", rep, {gnt1, gnt0}); end
      tick();
      req1 = 1'b0;
      wait_rsp(20, port, at);
      total++;
      if (port !== 1 || rsp_q !== 6'd7 || rsp_r !== 6'd2) begin
        bad++; $display("FAIL tie_rsp1 rep%0d got=p%0d %0d/%0d exp=p1 7/2", rep, port, rsp_q, rsp_r);
      end
    end
  endtask

  task automatic test_stream();
    int order[$];
    int exp_ord[4] = '{1, 0, 1, 1};
    logic pg0, pg1;
    int n1;
    do_reset();
    dly = 2; a1 = 6'd50; b1 = 6'd7; a0 = 6'd33; b0 = 6'd5; n1 = 0;
    tick();
    req1 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      pg0 = gnt0;
      pg1 = gnt1;
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (rsp_valid0) begin
        total++;
        if (rsp_q !== 6'd6 || rsp_r !== 6'd3) begin bad++; $display("FAIL stream_rsp0 got=%0d/%0d exp=6/3", rsp_q, rsp_r); end
      end
      if (rsp_valid1) begin
        total++;
        if (rsp_q !== 6'd7 || rsp_r !== 6'd1) begin bad++; $display("FAIL stream_rsp1 got=%0d/%0d exp=7/1", rsp_q, rsp_r); end
      end
      tick();
      if (pg0) req0 = 1'b0;
      if (pg1) begin
        n1++;
        if (n1 == 3) req1 = 1'b0;
      end
      if (k == 3) req0 = 1'b1;
    end
    total++;
    if (order.size() != 4) begin
      bad++; $display("FAIL stream_count got=%0d exp=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] != exp_ord[i]) begin bad++; $display("FAIL stream_order idx%0d got=%0d exp=%0d", i, order[i], exp_ord[i]); end
      end
    end
  endtask

  task automatic test_zero();
    int t0, port, at, s0;
    do_reset();
    dly = 4;
    tick();
    req0 = 1'b1; a0 = 6'd37; b0 = 6'd0;
    #1;
    t0 = cyc;
    s0 = n_start;
    total++;
    if (gnt0 !== 1'b1) begin bad++; $display("FAIL zero_gnt got=%b exp=1", gnt0); end
    tick();
    req0 = 1'b0;
    #1;
    if (rsp_valid0) begin
      port = 0;
      at   = cyc;
    end else begin
      wait_rsp(20, port, at);
    end
    total++;
    if (rsp_q !== 6'd63 || rsp_r !== 6'd37) begin bad++; $display("FAIL zero_val got=%0d/%0d exp=63/37", rsp_q, rsp_r); end
`ifdef DIV_ARB_ZERO_CHK_EN
    total++;
    if (port !== 0 || at !== t0 + 1 || rsp_err !== 1'b1) begin
      bad++; $display("FAIL zero_chk got=p%0d@%0d err=%b exp=p0@%0d err=1", port, at, rsp_err, t0 + 1);
    end
    tick();
    #1;
    total++;
    if (n_start !== s0) begin bad++; $display("FAIL zero_nostart got=%0d exp=%0d", n_start - s0, 0); end
`else
    total++;
    if (port !== 0 || at !== t0 + 2 + dly || rsp_err !== 1'b0) begin
      bad++; $display("FAIL zero_fwd got=p%0d@%0d err=%b exp=p0@%0d err=0", port, at, rsp_err, t0 + 2 + dly);
    end
    total++;
    if (n_start !== s0 + 1) begin bad++; $display("FAIL zero_start got=%0d exp=1", n_start - s0); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    int r0, port, at;
    do_reset();
    dly = 10;
    tick();
    req0 = 1'b1; a0 = 6'd60; b0 = 6'd7;
    tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    r0 = n_rsp;
    rst = 1'b1;
    dv_cnt = 0;
    #1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL midrst_async got=%0h exp=0", outs()); end
    tick(); tick();
    rst = 1'b0;
    tick();
    div_done = 1'b1; div_q = 6'd5; div_r = 6'd5;
    tick(); tick(); tick();
    #1;
    total++;
    if (n_rsp !== r0 || outs() !== '0) begin
      bad++; $display("FAIL midrst_quiet got=rsp%0d outs=%0h exp=rsp0 outs=0", n_rsp - r0, outs());
    end
    dly = 3;
    tick();
    req1 = 1'b1; a1 = 6'd17; b1 = 6'd5;
    #1;
    total++;
    if (gnt1 !== 1'b1) begin bad++; $display("FAIL midrst_regnt got=%b exp=1", gnt1); end
    tick();
    req1 = 1'b0;
    wait_rsp(20, port, at);
    total++;
    if (port !== 1 || rsp_q !== 6'd3 || rsp_r !== 6'd2) begin
      bad++; $display("FAIL midrst_fresh got=p%0d %0d/%0d exp=p1 3/2", port, rsp_q, rsp_r);
    end
  endtask

  task automatic test_spurious_done();
    int r0;
    do_reset();
    r0 = n_rsp;
    tick();
    div_done = 1'b1; div_q = 6'd9; div_r = 6'd9;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL spur_busy got=%b exp=0", busy); end
    tick(); tick(); tick();
    #1;
    total++;
    if (n_rsp !== r0 || busy !== 1'b0 || rsp_q !== 6'd0) begin
      bad++; $display("FAIL spur_ignored got=rsp%0d busy=%b q=%0d exp=rsp0 busy=0 q=0", n_rsp - r0, busy, rsp_q);
    end
  endtask

  // Transaction-level reference: a free/in-flight flag, a tie-break pointer
  // and the expected result of the current request.
  task automatic test_random();
    int inflight, gnt_cyc, resp_cyc, own, ptr, last_gp, win, nresp, zp;
    logic [W-1:0] ra, rb, eq, er;
    logic ee, e_busy, e_st;
    logic [1:0] e_g, e_v;
    do_reset();
    ptr = 0; inflight = 0; last_gp = -1; resp_cyc = -1; gnt_cyc = -100; own = 0; nresp = 0; zp = 0;
    ra = '0; rb = '0;
    for (int i = 0; i < 1500; i++) begin
      dly = $urandom_range(1, 6);
      tick();
      if (last_gp == 0) begin
        if ($urandom_range(0, 1) == 1) begin a0 = rnd_op(); b0 = rnd_b(); end else req0 = 1'b0;
      end else if (req0) begin
        if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req0 = 1'b1; a0 = rnd_op(); b0 = rnd_b();
      end
      if (last_gp == 1) begin
        if ($urandom_range(0, 1) == 1) begin a1 = rnd_op(); b1 = rnd_b(); end else req1 = 1'b0;
      end else if (req1) begin
        if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req1 = 1'b1; a1 = rnd_op(); b1 = rnd_b();
      end
      if (div_done && inflight == 1 && resp_cyc < 0) resp_cyc = cyc + 1;
      if (!div_done && (inflight == 0 || cyc == gnt_cyc + 1 || cyc == resp_cyc) &&
          $urandom_range(0, 5) == 0) begin
        div_done = 1'b1; div_q = rnd_op(); div_r = rnd_op();
      end
      #1;
      e_busy = (inflight == 1) && (cyc > gnt_cyc);
      e_st   = (inflight == 1) && (zp == 0) && (cyc == gnt_cyc + 1);
      e_v    = (inflight == 1 && cyc == resp_cyc) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00;
      win    = -1;
      if (inflight == 0 && (req0 || req1)) win = (req0 && req1) ? ptr : (req1 ? 1 : 0);
      e_g    = (win == 1) ? 2'b10 : ((win == 0) ? 2'b01 : 2'b00);
      total++;
      if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy cyc%0d got=%b exp=%b", cyc, busy, e_busy); end
      total++;
      if ({gnt1, gnt0} !== e_g) begin bad++; $display("FAIL rnd_gnt cyc%0d got=%b exp=%b", cyc, {gnt1, gnt0}, e_g); end
      total++;
      if (div_start !== e_st) begin bad++; $display("FAIL rnd_start cyc%0d got=%b exp=%b", cyc, div_start, e_st); end
      total++;
      if ({rsp_valid1, rsp_valid0} !== e_v) begin
        bad++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", cyc, {rsp_valid1, rsp_valid0}, e_v);
      end
      if (e_st) begin
        total++;
        if (div_dividend !== ra || div_divisor !== rb) begin
          bad++; $display("FAIL rnd_ops cyc%0d got=%0d/%0d exp=%0d/%0d", cyc, div_dividend, div_divisor, ra, rb);
        end
      end
      if (e_v != 2'b00) begin
        total++;
        if (rsp_q !== eq || rsp_r !== er || rsp_err !== ee) begin
          bad++; $display("FAIL rnd_rsp cyc%0d got=%0d/%0d/%b exp=%0d/%0d/%b", cyc, rsp_q, rsp_r, rsp_err, eq, er, ee);
        end
        inflight = 0;
        nresp++;
      end
      if (inflight == 1 && cyc - gnt_cyc > 20) begin
        total++; bad++;
        $display("FAIL rnd_timeout cyc%0d got=no response exp=response within 20 cycles", cyc);
        break;
      end
      last_gp = win;
      if (win >= 0) begin
        inflight = 1;
        gnt_cyc  = cyc;
        own      = win;
        ptr      = 1 - win;
        ra       = (win == 1) ? a1 : a0;
        rb       = (win == 1) ? b1 : b0;
`ifdef DIV_ARB_ZERO_CHK_EN
        zp = (rb == '0) ? 1 : 0;
`else
        zp = 0;
`endif
        resp_cyc = (zp == 1) ? cyc + 1 : -1;
        eq = (rb == '0) ? {W{1'b1}} : ra / rb;
        er = (rb == '0) ? ra : ra % rb;
        ee = (zp == 1);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    total++;
    if (nresp < 50) begin bad++; $display("FAIL rnd_progress got=%0d exp=>=50", nresp); end
    total++;
    if (n_dual != 0) begin bad++; $display("FAIL onehot got=%0d exp=0", n_dual); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_stream();
    test_zero();
    test_reset_mid_wait();
    test_spurious_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
